md_unit: RTL

Multiply/divide unit for the five-stage MIPS pipeline, located in the EX stage next to the ALU. It accepts mult/div/mthi/mtlo requests from the instruction in EX and holds the HI/LO registers. It drives the `Busy` signal that the hazard/stall logic combines with its decoded `isMD` to freeze IF/ID while a multi-cycle operation is in flight. Multiply and divide results are committed to HI/LO only at the end of their fixed latency.

---
 rtl/md_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit holding HI/LO, fixed-latency commit.
// Define MD_MADD_EN to enable madd/maddu (MDOp 6/7) accumulate into {HI,LO}.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  localparam logic [3:0] MUL_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT = 4'(DIV_CYCLES);

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        start_launch;
  logic        new_is_div;

  function automatic logic is_launch(input logic [2:0] op);
`ifdef MD_MADD_EN
    return (op != OP_MTHI) && (op != OP_MTLO);
`else
    return !op[2];
`endif
  endfunction

  assign start_launch = Start & is_launch(MDOp);
  assign new_is_div   = !MDOp[2] & MDOp[1];

  assign Busy = (state_q == S_RUN) | start_launch;
  assign HI   = hi_q;
  assign LO   = lo_q;

  // Datapath works on the latched operands so the forwarded inputs may change.
  logic        sgn;
  logic        op_div;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  always_comb begin
    sgn    = !op_q[0];
    op_div = !op_q[2] & op_q[1];
    a_ext  = sgn ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    b_ext  = sgn ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    prod   = a_ext * b_ext;
    a_neg  = sgn & a_q[31];
    b_neg  = sgn & b_q[31];
    a_mag  = a_neg ? (32'd0 - a_q) : a_q;
    b_mag  = b_neg ? (32'd0 - b_q) : b_q;
    q_mag  = 32'd0;
    r_mag  = 32'd0;
    if (b_q != 32'd0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quo = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem = a_neg ? (32'd0 - r_mag) : r_mag;
  end

`ifdef MD_MADD_EN
  logic [63:0] acc;
  assign acc = {hi_q, lo_q} + prod;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == S_IDLE) begin
      if (start_launch) begin
        a_d     = A;
        b_d     = B;
        op_d    = MDOp;
        cnt_d   = new_is_div ? DIV_LAT : MUL_LAT;
        state_d = S_RUN;
      end else if (Start && MDOp == OP_MTHI) begin
        hi_d = A;
      end else if (Start && MDOp == OP_MTLO) begin
        lo_d = A;
      end
    end else begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = S_IDLE;
        unique case (1'b1)
          op_div: begin
            // Divide by zero still burns the latency but leaves HI/LO alone.
            if (b_q != 32'd0) begin
              hi_d = rem;
              lo_d = quo;
            end
          end
`ifdef MD_MADD_EN
          op_q[2]: {hi_d, lo_d} = acc;
`endif
          default: {hi_d, lo_d} = prod;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 3'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule
